// File: rtl/freq_div_ctrl_pkg.sv
// Shared types and helpers for the programmable clock divider.
// The state enumeration, the minimum legal ratio and the ceil-half duty helper.
package freq_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOP
    } state_t;

    localparam int MIN_RATIO = 2;
    localparam int CALC_W    = 16;

    // Split as n/2 + lsb so that n = 2^CALC_W-1 cannot overflow.
    function automatic logic [CALC_W-1:0] ceil_half(input logic [CALC_W-1:0] n);
        return (n >> 1) + {{(CALC_W-1){1'b0}}, n[0]};
    endfunction

endpackage

// File: rtl/freq_div_ctrl_if.sv
// Ratio configuration handshake between a host and the divider controller.
interface freq_div_ctrl_if #(
    parameter int RW = 4
);
    logic          cfg_valid;
    logic [RW-1:0] cfg_ratio;
    logic          cfg_ready;

    modport master (output cfg_valid, output cfg_ratio, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ratio, output cfg_ready);
endinterface

// File: rtl/freq_div_ctrl_counter.sv
// Period counter for the divider: wraps at active_ratio-1 and decodes clk_out/tick
// purely from the cnt, running and ratio registers.
module div_counter
    import freq_div_ctrl_pkg::*;
#(
    parameter int RW = 4
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          running,
    input  logic [RW-1:0] ratio,
    output logic [RW-1:0] cnt,
    output logic          boundary,
    output logic          clk_out,
    output logic          tick
);

    always_ff @(posedge clk_in) begin
        if (rst || !running || boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + RW'(1);
        end
    end

    assign boundary = running && (cnt == ratio - RW'(1));
    assign tick     = running && (cnt == '0);
    assign clk_out  = running && (CALC_W'(cnt) < ceil_half(CALC_W'(ratio)));

endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable integer clock divider: run/stop FSM, ratio handshake with
// deferred application so a period in progress is never resized.
module freq_div_ctrl
    import freq_div_ctrl_pkg::*;
#(
    parameter int RW            = 4,
    parameter int DEFAULT_RATIO = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              enable,
    freq_div_ctrl_if.slave    cfg,
    output logic              clk_out,
    output logic              tick,
    output logic              busy,
    output logic              cfg_err,
    output logic [RW-1:0]     active_ratio
);

    state_t        state, state_n;
    logic [RW-1:0] ratio_n;
    logic [RW-1:0] pending, pending_n;
    logic          pend_valid, pend_valid_n;
    logic [RW-1:0] cnt;
    logic          boundary;
    logic          accept, load, bad;

    assign cfg.cfg_ready = (state != PEND);
    assign busy          = (state != IDLE);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign load          = accept && (cfg.cfg_ratio >= RW'(MIN_RATIO));
    assign bad           = accept && (cfg.cfg_ratio <  RW'(MIN_RATIO));

    div_counter #(.RW(RW)) u_counter (
        .clk_in   (clk_in),
        .rst      (rst),
        .running  (busy),
        .ratio    (active_ratio),
        .cnt      (cnt),
        .boundary (boundary),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            active_ratio <= RW'(DEFAULT_RATIO);
            pending      <= '0;
            pend_valid   <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= state_n;
            active_ratio <= ratio_n;
            pending      <= pending_n;
            pend_valid   <= pend_valid_n;
            cfg_err      <= bad;
        end
    end

    // Ratio changes only take effect at a boundary; a held ratio survives STOP.
    always_comb begin
        state_n      = state;
        ratio_n      = active_ratio;
        pending_n    = pending;
        pend_valid_n = pend_valid;
        case (state)
            IDLE: begin
                if (load) ratio_n = cfg.cfg_ratio;
                if (enable) state_n = RUN;
            end
            RUN, PEND, STOP: begin
                if (boundary) begin
                    if (pend_valid) begin
                        ratio_n      = pending;
                        pend_valid_n = 1'b0;
                    end
                    if (load) ratio_n = cfg.cfg_ratio;
                    state_n = enable ? RUN : IDLE;
                end else begin
                    if (load) begin
                        pending_n    = cfg.cfg_ratio;
                        pend_valid_n = 1'b1;
                    end
                    if (enable) state_n = pend_valid_n ? PEND : RUN;
                    else        state_n = STOP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Scoreboard bench for freq_div_ctrl: expected {clk_out,tick,busy,cfg_ready}
// per cycle are queued from the ratio being driven and popped each cycle.
module tb_freq_div_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       enable;
    logic       clk_out, tick, busy, cfg_err;
    logic [3:0] active_ratio;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v, obs_v;

    freq_div_ctrl_if #(.RW(4)) cfg_bus ();

    freq_div_ctrl #(.RW(4), .DEFAULT_RATIO(2)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .cfg          (cfg_bus),
        .clk_out      (clk_out),
        .tick         (tick),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .active_ratio (active_ratio)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        enable            = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ratio = 4'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic load_idle(input logic [3:0] n);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ratio = n;
        step();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    // Expected per-cycle pattern straight from the duty rule: high for ceil(n/2).
    task automatic push_period(input int n, input int periods);
        logic hi, tk;
        for (int p = 0; p < periods; p++) begin
            for (int c = 0; c < n; c++) begin
                hi = (c < (n + 1) / 2);
                tk = (c == 0);
                exp_q.push_back({hi, tk, 1'b1, 1'b1});
            end
        end
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        enable            = 1'b1;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ratio = 4'd1;
        step();
        step();
        n_compared++;
        if ({clk_out, tick, busy, cfg_err} !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000", {clk_out, tick, busy, cfg_err});
        end
        n_compared++;
        if (active_ratio !== 4'd2) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ratio: got %0d expected 2", active_ratio);
        end
        rst               = 1'b0;
        enable            = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        step();
        n_compared++;
        if (cfg_bus.cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0",
                     cfg_bus.cfg_ready, busy);
        end
    endtask

    task automatic test_default_ratio();
        do_reset();
        enable = 1'b1;
        step();
        push_period(2, 3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            exp_v = exp_q.pop_front();
            obs_v = {clk_out, tick, busy, cfg_bus.cfg_ready};
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL default_ratio cycle %0d: got %b expected %b", i, obs_v, exp_v);
            end
            step();
        end
    endtask

    task automatic test_ratio3();
        do_reset();
        load_idle(4'd3);
        n_compared++;
        if (active_ratio !== 4'd3 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_load: got ratio=%0d busy=%b expected ratio=3 busy=0",
                     active_ratio, busy);
        end
        enable = 1'b1;
        step();
        push_period(3, 3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            exp_v = exp_q.pop_front();
            obs_v = {clk_out, tick, busy, cfg_bus.cfg_ready};
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL ratio3 cycle %0d: got %b expected %b", i, obs_v, exp_v);
            end
            step();
        end
    endtask

    task automatic test_pend();
        do_reset();
        load_idle(4'd4);
        enable = 1'b1;
        step();
        push_period(4, 1);
        push_period(6, 2);
        exp_q[2] = exp_q[2] & 4'b1110;
        exp_q[3] = exp_q[3] & 4'b1110;
        for (int i = 0; exp_q.size() > 0; i++) begin
            exp_v = exp_q.pop_front();
            obs_v = {clk_out, tick, busy, cfg_bus.cfg_ready};
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL pend cycle %0d: got %b expected %b", i, obs_v, exp_v);
            end
            if (i == 3) begin
                n_compared++;
                if (active_ratio !== 4'd4) begin
                    n_mismatched++;
                    $display("[TB] FAIL pend_hold_ratio: got %0d expected 4", active_ratio);
                end
            end
            cfg_bus.cfg_valid = (i == 1);
            cfg_bus.cfg_ratio = 4'd6;
            step();
        end
        n_compared++;
        if (active_ratio !== 4'd6) begin
            n_mismatched++;
            $display("[TB] FAIL pend_applied: got %0d expected 6", active_ratio);
        end
    endtask

    task automatic test_boundary_load();
        do_reset();
        enable = 1'b1;
        step();
        push_period(2, 2);
        push_period(5, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            exp_v = exp_q.pop_front();
            obs_v = {clk_out, tick, busy, cfg_bus.cfg_ready};
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL boundary_load cycle %0d: got %b expected %b", i, obs_v, exp_v);
            end
            cfg_bus.cfg_valid = (i == 3);
            cfg_bus.cfg_ratio = 4'd5;
            step();
        end
    endtask

    task automatic test_illegal();
        logic exp_err;
        do_reset();
        load_idle(4'd4);
        enable = 1'b1;
        step();
        push_period(4, 3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            exp_v   = exp_q.pop_front();
            obs_v   = {clk_out, tick, busy, cfg_bus.cfg_ready};
            exp_err = (i == 2);
            n_compared++;
            if (obs_v !== exp_v || cfg_err !== exp_err) begin
                n_mismatched++;
                $display("[TB] FAIL illegal cycle %0d: got %b err=%b expected %b err=%b",
                         i, obs_v, cfg_err, exp_v, exp_err);
            end
            cfg_bus.cfg_valid = (i == 1);
            cfg_bus.cfg_ratio = 4'd1;
            step();
        end
        n_compared++;
        if (active_ratio !== 4'd4) begin
            n_mismatched++;
            $display("[TB] FAIL illegal_ratio_kept: got %0d expected 4", active_ratio);
        end
    endtask

    task automatic test_stop();
        do_reset();
        load_idle(4'd4);
        enable = 1'b1;
        step();
        push_period(4, 1);
        repeat (3) exp_q.push_back(4'b0001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            exp_v = exp_q.pop_front();
            obs_v = {clk_out, tick, busy, cfg_bus.cfg_ready};
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL stop cycle %0d: got %b expected %b", i, obs_v, exp_v);
            end
            if (i == 1) enable = 1'b0;
            step();
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        load_idle(4'd6);
        enable = 1'b1;
        repeat (3) step();
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ratio = 4'd3;
        step();
        cfg_bus.cfg_valid = 1'b0;
        n_compared++;
        if (cfg_bus.cfg_ready !== 1'b0 || clk_out !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_pend: got ready=%b clk_out=%b expected ready=0 clk_out=0",
                     cfg_bus.cfg_ready, clk_out);
        end
        rst = 1'b1;
        step();
        n_compared++;
        if ({clk_out, tick, busy, cfg_err} !== 4'b0000 || active_ratio !== 4'd2) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_outputs: got %b ratio=%0d expected 0000 ratio=2",
                     {clk_out, tick, busy, cfg_err}, active_ratio);
        end
        rst    = 1'b0;
        enable = 1'b0;
        step();
        n_compared++;
        if (tick !== 1'b0 || busy !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_release: got tick=%b busy=%b ready=%b expected 0 0 1",
                     tick, busy, cfg_bus.cfg_ready);
        end
        enable = 1'b1;
        step();
        push_period(2, 2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            exp_v = exp_q.pop_front();
            obs_v = {clk_out, tick, busy, cfg_bus.cfg_ready};
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL rst_pending_discarded cycle %0d: got %b expected %b",
                         i, obs_v, exp_v);
            end
            step();
        end
    endtask

    initial begin
        rst               = 1'b1;
        enable            = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ratio = 4'd0;
        test_reset();
        test_default_ratio();
        test_ratio3();
        test_pend();
        test_boundary_load();
        test_illegal();
        test_stop();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
